// File: rtl/adder_pkg.sv
// Shared constants and chunk sizing for the pipelined add/subtract unit.
package adder_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_STAGES = 4;

    // Bits per carry chunk; returns 0 for an illegal width/stage pairing.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        if (stages == 0 || stages > width || (width % stages) != 0) begin
            return 0;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle between producers, pipe_adder and consumers.
interface pipe_adder_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice; exposes the carry into its MSB for overflow detection.
module adder_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);
    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    assign s    = full[W-1:0];
    assign cout = full[W];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign cmsb = a[W-1] ^ b[W-1] ^ s[W-1];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one carry chunk per stage, skewed operands in, de-skewed result out,
// global stall on output backpressure.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input logic         clk,
    input logic         rst_n,
    pipe_adder_if.slave bus
);
    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (CHUNK == 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic              en;
    logic [WIDTH-1:0]  b_eff;
    logic              last_src_valid;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    // Stage i word: result in chunks 0..i, untouched operand A above.
    logic [WIDTH-1:0]  aw_q [STAGES];
    logic [WIDTH-1:0]  aw_d [STAGES];
    logic [WIDTH-1:0]  bw_q [STAGES];
    logic [WIDTH-1:0]  bw_d [STAGES];
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  ca [STAGES];
    logic [CHUNK-1:0]  cb [STAGES];
    logic [CHUNK-1:0]  cs [STAGES];
    logic [STAGES-1:0] ccin;
    logic [STAGES-1:0] ccout;
    logic              ccmsb [STAGES];

    assign en           = !valid_q[STAGES-1] | bus.out_ready;
    assign bus.in_ready = en;
    assign b_eff        = bus.b ^ {WIDTH{bus.sub}};

    // Chunk 0 works on the live operands; later chunks on the previous stage's skewed copy.
    for (genvar i = 0; i < int'(STAGES); i++) begin : g_chunk
        if (i == 0) begin : g_first
            assign ca[i]   = bus.a[CHUNK-1:0];
            assign cb[i]   = b_eff[CHUNK-1:0];
            assign ccin[i] = bus.sub;
        end else begin : g_rest
            assign ca[i]   = aw_q[i-1][i*CHUNK +: CHUNK];
            assign cb[i]   = bw_q[i-1][i*CHUNK +: CHUNK];
            assign ccin[i] = carry_q[i-1];
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a   (ca[i]),
            .b   (cb[i]),
            .cin (ccin[i]),
            .s   (cs[i]),
            .cout(ccout[i]),
            .cmsb(ccmsb[i])
        );
    end

    if (STAGES == 1) begin : g_last_single
        assign last_src_valid = bus.in_valid;
    end else begin : g_last_multi
        assign last_src_valid = valid_q[STAGES-2];
    end

    // Next-state: hold everything on stall, otherwise shift one stage.
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        aw_d    = aw_q;
        bw_d    = bw_q;
        ovf_d   = ovf_q;
        if (en) begin
            valid_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                aw_d[0]            = bus.a;
                aw_d[0][CHUNK-1:0] = cs[0];
                bw_d[0]            = b_eff;
                carry_d[0]         = ccout[0];
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    aw_d[i]                    = aw_q[i-1];
                    aw_d[i][i*CHUNK +: CHUNK]  = cs[i];
                    bw_d[i]                    = bw_q[i-1];
                    carry_d[i]                 = ccout[i];
                end
            end
            if (last_src_valid) begin
                ovf_d = ccmsb[STAGES-1] ^ ccout[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < int'(STAGES); i++) begin
                aw_q[i] <= '0;
                bw_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < int'(STAGES); i++) begin
                aw_q[i] <= aw_d[i];
                bw_q[i] <= bw_d[i];
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = {carry_q[STAGES-1], aw_q[STAGES-1]};
    assign bus.ovf       = ovf_q;
endmodule
